// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle ALU between the operand latches (A/B)
// and the result register C of the datapath.
//
// Parameters
//   W     operand/result width (W >= 4)
//   SH_W  width of the shift-amount field taken from Bin[SH_W-1:0]
//         (2**SH_W >= W)
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   request, sampled only while idle
//   Ain     operand A
//   Bin     operand B
//   ALUop   operation select, sampled with start
//   out     registered result
//   status  registered flags {V, N, Z}
//   busy    high from the cycle after accept until done
//   done    single-cycle pulse when out/status update
//
// Configuration
//   ALU_SEQ_MUL_EN  when defined, op 3'b111 runs an iterative W-cycle
//                   shift-add multiplier. When undefined, op 3'b111 is
//                   illegal and returns out=0, status=3'b100.
module alu_seq #(
  parameter int W    = 16,
  parameter int SH_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  input  logic [2:0]   ALUop,
  output logic [W-1:0] out,
  output logic [2:0]   status,
  output logic         busy,
  output logic         done
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, EXEC, MUL, FIN} stateT;
  localparam int CNT_W = $clog2(W) + 1;
`else
  typedef enum logic [1:0] {IDLE, EXEC} stateT;
`endif

  stateT state;

  logic [W-1:0] aReg;
  logic [W-1:0] bReg;
  logic [2:0]   opReg;

`ifdef ALU_SEQ_MUL_EN
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
`endif

  logic [W-1:0]    execOut;
  logic            execV;
  logic [2:0]      execFlags;
  logic [SH_W-1:0] shAmt;
  logic [2*W-1:0]  shiftWide;

  // Single-cycle result of the latched operands. The shift is done in a
  // double-width vector so the bits pushed past the MSB can be inspected
  // for the V flag; amounts of W or more clear the result, and V then
  // reports whether A had any set bit at all. Op 111 only lands here when
  // the multiplier is absent, so it is reported as an illegal op with V
  // set and Z deliberately left clear.
  always_comb begin
    execOut   = '0;
    execV     = 1'b0;
    shiftWide = '0;
    shAmt     = bReg[SH_W-1:0];
    case (opReg)
      3'b000: begin
        execOut = aReg + bReg;
        execV   = (aReg[W-1] == bReg[W-1]) && (execOut[W-1] != aReg[W-1]);
      end
      3'b001: begin
        execOut = aReg - bReg;
        execV   = (aReg[W-1] != bReg[W-1]) && (execOut[W-1] != aReg[W-1]);
      end
      3'b010: execOut = aReg & bReg;
      3'b011: execOut = ~bReg;
      3'b100: execOut = aReg | bReg;
      3'b101: execOut = aReg ^ bReg;
      3'b110: begin
        if (int'(shAmt) >= W) begin
          execOut = '0;
          execV   = |aReg;
        end else begin
          shiftWide = {{W{1'b0}}, aReg} << shAmt;
          execOut   = shiftWide[W-1:0];
          execV     = |shiftWide[2*W-1:W];
        end
      end
      default: begin
        execOut = '0;
        execV   = 1'b1;
      end
    endcase
    if (opReg == 3'b111) begin
      execFlags = 3'b100;
    end else begin
      execFlags = {execV, execOut[W-1], execOut == '0};
    end
  end

  // Control FSM with registered outputs. Operands are captured on accept
  // so later changes on Ain/Bin/ALUop cannot disturb an operation in
  // flight. busy falls on the same edge that raises done, so a new
  // request can be accepted on the very next edge. The multiplier always
  // runs exactly W iterations (one B bit per cycle, LSB first) so its
  // latency does not depend on the operand values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      out    <= '0;
      status <= 3'b000;
      busy   <= 1'b0;
      done   <= 1'b0;
      aReg   <= '0;
      bReg   <= '0;
      opReg  <= 3'b000;
`ifdef ALU_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            aReg  <= Ain;
            bReg  <= Bin;
            opReg <= ALUop;
            busy  <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            if (ALUop == 3'b111) begin
              acc    <= '0;
              mcand  <= {{W{1'b0}}, Ain};
              mplier <= Bin;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              state <= EXEC;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          out    <= execOut;
          status <= execFlags;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(W - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          out    <= acc[W-1:0];
          status <= {|acc[2*W-1:W], acc[W-1], acc[W-1:0] == '0};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (W=16, SH_W=5).
// Stimulus pushes the expected result, flags and latency computed with
// plain integer arithmetic; an independent monitor pops and compares on
// every done pulse.
module tb_alu_seq;

  localparam int W    = 16;
  localparam int SH_W = 5;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic [2:0]   ALUop;
  logic [W-1:0] out;
  logic [2:0]   status;
  logic         busy;
  logic         done;

  typedef struct {
    logic [W-1:0] out;
    logic [2:0]   status;
    int           accept;
    int           lat;
  } expT;

  expT sbQ[$];
  int  checks;
  int  errors;
  int  cycle;

  alu_seq #(.W(W), .SH_W(SH_W)) dut (
    .clk(clk), .reset(reset), .start(start), .Ain(Ain), .Bin(Bin),
    .ALUop(ALUop), .out(out), .status(status), .busy(busy), .done(done)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to measure accept-to-done latency.
  always @(posedge clk) begin
    cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: signed overflow from integer range checks, shifts and
  // products in 64-bit arithmetic, flags taken from the final result.
  function automatic expT model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
    expT e;
    int sa, sb, r;
    longint p;
    logic [W-1:0] o;
    logic v;
    int amt;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    v   = 1'b0;
    o   = '0;
    p   = 0;
    r   = 0;
    amt = int'(b) % (1 << SH_W);
    e.lat = 1;
    e.accept = 0;
    case (op)
      3'd0: begin r = sa + sb; o = a + b; v = (r > 32767) || (r < -32768); end
      3'd1: begin r = sa - sb; o = a - b; v = (r > 32767) || (r < -32768); end
      3'd2: o = a & b;
      3'd3: o = ~b;
      3'd4: o = a | b;
      3'd5: o = a ^ b;
      3'd6: begin
        p = longint'(a) << amt;
        o = p[W-1:0];
        v = (p >> W) != 0;
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        p = longint'(a) * longint'(b);
        o = p[W-1:0];
        v = (p >> W) != 0;
        e.lat = W + 1;
`else
        e.out    = '0;
        e.status = 3'b100;
        return e;
`endif
      end
    endcase
    e.out    = o;
    e.status = {v, o[W-1], o == '0};
    return e;
  endfunction

  // Wait at negedges for done, bounded; returns on the done negedge.
  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_done: done=%0b after %0d cycles, expected 1", done, n);
    end
  endtask

  // Called at a negedge: issue one request, scramble inputs after accept,
  // and return on the done negedge so the next call is back-to-back.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    expT e;
    e = model(op, a, b);
    e.accept = cycle + 1;
    sbQ.push_back(e);
    start = 1'b1;
    ALUop = op;
    Ain   = a;
    Bin   = b;
    @(negedge clk);
    start = 1'b0;
    ALUop = 3'($urandom);
    Ain   = W'($urandom);
    Bin   = W'($urandom);
    waitDone();
  endtask

  // Like applyStimulus, but keeps start high with a different request for
  // the whole busy period; it must be ignored.
  task automatic applyWhileBusy(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [2:0] op2);
    expT e;
    e = model(op, a, b);
    e.accept = cycle + 1;
    sbQ.push_back(e);
    start = 1'b1;
    ALUop = op;
    Ain   = a;
    Bin   = b;
    @(negedge clk);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    ALUop = op2;
    Ain   = 16'h0F0F;
    Bin   = 16'h0101;
    waitDone();
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: out=%0h status=%0b with no request pending", out, status);
      end else begin
        expT e;
        e = sbQ.pop_front();
        checkOutput("out", 32'(out), 32'(e.out));
        checkOutput("status", 32'(status), 32'(e.status));
        checkOutput("latency", 32'(cycle - e.accept), 32'(e.lat));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    ALUop  = 3'b000;
    Ain    = '0;
    Bin    = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_out", 32'(out), 32'd0);
    checkOutput("rst_status", 32'(status), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(3'b000, 16'h7FFF, 16'h0001);
    applyWhileBusy(3'b001, 16'h1234, 16'h1234, 3'b000);
    applyStimulus(3'b110, 16'hC001, 16'h0001);
    applyStimulus(3'b110, 16'hC001, 16'h0010);
    applyStimulus(3'b111, 16'h0100, 16'h0100);
    applyStimulus(3'b111, 16'h0007, 16'h0006);
    applyWhileBusy(3'b111, 16'h0003, 16'h0005, 3'b010);
    applyStimulus(3'b011, 16'h0000, 16'hFFFF);
    @(negedge clk);

    // Abort a request in flight with reset; it must never report done.
    start = 1'b1;
    ALUop = 3'b111;
    Ain   = 16'h0003;
    Bin   = 16'h0005;
    @(negedge clk);
    start = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    repeat (2) @(negedge clk);
`endif
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_out", 32'(out), 32'd0);
    checkOutput("abort_status", 32'(status), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("idle_hold_out", 32'(out), 32'd0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
